// File: rtl/cordic_iter_if.sv
// Operand/result handshake bundle between the CORDIC engine, its operand
// source and its result consumer.
interface cordic_iter_if #(
    parameter int unsigned L = 16
);
    logic                start;
    logic                vectoring;
    logic signed [L-1:0] x_in;
    logic signed [L-1:0] y_in;
    logic signed [L-1:0] z_in;
    logic                ready;
    logic                valid;
    logic signed [L-1:0] x_out;
    logic signed [L-1:0] y_out;
    logic signed [L-1:0] z_out;

    modport master (
        output start, vectoring, x_in, y_in, z_in,
        input  ready, valid, x_out, y_out, z_out
    );

    modport slave (
        input  start, vectoring, x_in, y_in, z_in,
        output ready, valid, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per clock over signed fixed-point x/y/z,
// with the per-step angle constant returned combinationally by an alpha table.
module cordic_iter #(
    parameter int unsigned DEC  = 2,
    parameter int unsigned FRAC = 14,
    parameter int          MOD  = 1,   // 1 circular, 0 linear, -1 hyperbolic
    localparam int unsigned L        = DEC + FRAC,
    localparam int unsigned ITER     = FRAC + 1,
    localparam int unsigned LOG_ITER = $clog2(ITER)
) (
    input  logic                clk,
    input  logic                rst_n,
    cordic_iter_if.slave        bus,
    output logic [LOG_ITER-1:0] iter,
    input  logic signed [L-1:0] alphai
);

    // Hyperbolic convergence needs shifts 4 and 13 executed twice.
    localparam int unsigned HYP_REP_A = 4;
    localparam int unsigned HYP_REP_B = 13;
    localparam int unsigned N_STEPS   = (MOD < 0) ? ITER + 1 : ITER;
    localparam int unsigned STEP_W    = $clog2(N_STEPS);
    localparam int unsigned IW        = LOG_ITER + 1;
    localparam logic [LOG_ITER-1:0] FIRST_ITER = (MOD < 0) ? LOG_ITER'(1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                vec_q, vec_d;
    logic signed [L-1:0] x_q, x_d;
    logic signed [L-1:0] y_q, y_d;
    logic signed [L-1:0] z_q, z_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;

    logic [IW-1:0]       hyp_s;
    logic                d_pos;
    logic signed [L-1:0] x_sh, y_sh;
    logic signed [L-1:0] x_upd, y_upd, z_upd;

    // Shift index: equals the step count, except hyperbolic starts at 1 and repeats.
    always_comb begin
        hyp_s = IW'(step_q) + IW'(1);
        if (step_q >= STEP_W'(HYP_REP_A)) hyp_s = hyp_s - IW'(1);
        if (step_q >= STEP_W'(HYP_REP_B + 1)) hyp_s = hyp_s - IW'(1);
        iter = FIRST_ITER;
        if (state_q == RUN) begin
            iter = (MOD < 0) ? LOG_ITER'(hyp_s) : LOG_ITER'(step_q);
        end
    end

    // One micro-rotation from the pre-update x/y/z.
    always_comb begin
        x_sh  = x_q >>> iter;
        y_sh  = y_q >>> iter;
        d_pos = vec_q ? y_q[L-1] : ~z_q[L-1];
        x_upd = x_q;
        if (MOD != 0) begin
            x_upd = (d_pos ^ (MOD < 0)) ? (x_q - y_sh) : (x_q + y_sh);
        end
        y_upd = d_pos ? (y_q + x_sh) : (y_q - x_sh);
        z_upd = d_pos ? (z_q - alphai) : (z_q + alphai);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        vec_d   = vec_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    step_d  = '0;
                    vec_d   = bus.vectoring;
                    x_d     = bus.x_in;
                    y_d     = bus.y_in;
                    z_d     = bus.z_in;
                end
            end
            RUN: begin
                x_d = x_upd;
                y_d = y_upd;
                z_d = z_upd;
                if (step_q == STEP_W'(N_STEPS - 1)) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            vec_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            vec_q   <= vec_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.valid = valid_q;
    assign bus.x_out = x_q;
    assign bus.y_out = y_q;
    assign bus.z_out = z_q;

endmodule
